// File: rtl/ball_pkg.sv
// Shared types and helpers for the multi-ball bouncer: FSM states, direction
// encoding, per-axis motion step and the index-to-colour mapping.
package ball_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_UPDATE,
    S_DONE
  } state_e;

  localparam logic DIR_INC = 1'b0;
  localparam logic DIR_DEC = 1'b1;

  typedef struct packed {
    logic [8:0] pos;
    logic       dir;
    logic       clamp;
  } axis_t;

  // One frame of motion along one axis; 10-bit math keeps pos+spd from wrapping.
  function automatic axis_t axis_step(input logic [8:0] pos, input logic dir,
                                      input logic [9:0] spd, input logic [9:0] lim);
    axis_t      r;
    logic [9:0] p;
    p       = {1'b0, pos};
    r.pos   = pos;
    r.dir   = dir;
    r.clamp = 1'b0;
    if (dir == DIR_INC) begin
      if (p + spd >= lim) begin
        r.pos   = lim[8:0];
        r.dir   = DIR_DEC;
        r.clamp = 1'b1;
      end else begin
        r.pos = 9'(p + spd);
      end
    end else begin
      if (p <= spd) begin
        r.pos   = '0;
        r.dir   = DIR_INC;
        r.clamp = 1'b1;
      end else begin
        r.pos = 9'(p - spd);
      end
    end
    return r;
  endfunction

  function automatic logic [2:0] ball_colour(input int unsigned idx);
    return 3'((idx % 7) + 1);
  endfunction

endpackage

// File: rtl/ball_hit_test.sv
// Combinational test of whether the current pixel lies inside one square ball.
module ball_hit_test #(
  parameter int BALL_SIZE = 4
) (
  input  logic [8:0] hpos_i,
  input  logic [8:0] vpos_i,
  input  logic [8:0] x_i,
  input  logic [8:0] y_i,
  output logic       hit_o
);

  logic [9:0] dx, dy;

  // Pixels left of / above the ball wrap to large values and fail the test.
  assign dx    = {1'b0, hpos_i} - {1'b0, x_i};
  assign dy    = {1'b0, vpos_i} - {1'b0, y_i};
  assign hit_o = (dx < 10'(BALL_SIZE)) && (dy < 10'(BALL_SIZE));

endmodule

// File: rtl/ball_multi.sv
// NUM_BALLS bouncing squares: one ball moves per cycle after each vsync rise,
// and a registered priority renderer paints the lowest-index ball on top.
module ball_multi
  import ball_pkg::*;
#(
  parameter int NUM_BALLS = 4,
  parameter int BALL_SIZE = 4,
  parameter int H_MAX     = 256,
  parameter int V_MAX     = 240,
  parameter int H_SPEED   = 2,
  parameter int V_SPEED   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pause,
  input  logic       vsync,
  input  logic       display_on,
  input  logic [8:0] hpos,
  input  logic [8:0] vpos,
  output logic [2:0] rgb,
  output logic       bounce,
  output logic       busy
);

  localparam int         IW    = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
  localparam logic [9:0] X_LIM = 10'(H_MAX - BALL_SIZE);
  localparam logic [9:0] Y_LIM = 10'(V_MAX - BALL_SIZE);
  localparam logic [9:0] H_SPD = 10'(H_SPEED);
  localparam logic [9:0] V_SPD = 10'(V_SPEED);

  state_e                      state_q, state_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic                        vsync_q, clamp_q, clamp_d;
  logic [2:0]                  rgb_q, rgb_d;
  logic [NUM_BALLS-1:0][8:0]   x_q, y_q;
  logic [NUM_BALLS-1:0]        hdir_q, vdir_q;
  logic [NUM_BALLS-1:0]        hit;
  logic                        vsync_rise;
  axis_t                       hstep, vstep;

  assign vsync_rise = vsync & ~vsync_q;
  assign hstep      = axis_step(x_q[idx_q], hdir_q[idx_q], H_SPD, X_LIM);
  assign vstep      = axis_step(y_q[idx_q], vdir_q[idx_q], V_SPD, Y_LIM);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    clamp_d = clamp_q;
    unique case (state_q)
      S_IDLE: begin
        if (vsync_rise && !pause) begin
          state_d = S_UPDATE;
          idx_d   = '0;
          clamp_d = 1'b0;
        end
      end
      S_UPDATE: begin
        clamp_d = clamp_q | hstep.clamp | vstep.clamp;
        if (idx_q == IW'(NUM_BALLS - 1)) state_d = S_DONE;
        else                             idx_d   = idx_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      vsync_q <= 1'b0;
      clamp_q <= 1'b0;
      rgb_q   <= '0;
      for (int i = 0; i < NUM_BALLS; i++) begin
        x_q[i]    <= 9'(32 * i + 16);
        y_q[i]    <= 9'(24 * i + 16);
        hdir_q[i] <= i[0];
        vdir_q[i] <= i[1];
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vsync_q <= vsync;
      clamp_q <= clamp_d;
      rgb_q   <= rgb_d;
      if (state_q == S_UPDATE) begin
        x_q[idx_q]    <= hstep.pos;
        hdir_q[idx_q] <= hstep.dir;
        y_q[idx_q]    <= vstep.pos;
        vdir_q[idx_q] <= vstep.dir;
      end
    end
  end

  for (genvar g = 0; g < NUM_BALLS; g++) begin : g_hit
    ball_hit_test #(.BALL_SIZE(BALL_SIZE)) u_hit (
      .hpos_i (hpos),
      .vpos_i (vpos),
      .x_i    (x_q[g]),
      .y_i    (y_q[g]),
      .hit_o  (hit[g])
    );
  end

  // Scan high-to-low so the lowest-index hit is the last write and wins.
  always_comb begin
    rgb_d = '0;
    if (display_on) begin
      for (int i = NUM_BALLS - 1; i >= 0; i--) begin
        if (hit[i]) rgb_d = ball_colour(i);
      end
    end
  end

  assign rgb    = rgb_q;
  assign busy   = (state_q == S_UPDATE);
  assign bounce = (state_q == S_DONE) & clamp_q;

endmodule

// File: tb/tb_ball_multi.sv
// Randomized bench for ball_multi against an integer reference model of the balls.
module tb_ball_multi;

  localparam int N = 4, BS = 4, HM = 256, VM = 240, HSP = 2, VSP = 2;

  logic       clk = 1'b0;
  logic       reset, pause, vsync, display_on;
  logic [8:0] hpos, vpos;
  logic [2:0] rgb;
  logic       bounce, busy;

  always #5 clk = ~clk;

  ball_multi #(
    .NUM_BALLS(N), .BALL_SIZE(BS), .H_MAX(HM), .V_MAX(VM), .H_SPEED(HSP), .V_SPEED(VSP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pause      (pause),
    .vsync      (vsync),
    .display_on (display_on),
    .hpos       (hpos),
    .vpos       (vpos),
    .rgb        (rgb),
    .bounce     (bounce),
    .busy       (busy)
  );

  int n_chk = 0, n_pass = 0;
  int mx[N], my[N], mh[N], mv[N];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i] = 32 * i + 16;
      my[i] = 24 * i + 16;
      mh[i] = i & 1;
      mv[i] = (i >> 1) & 1;
    end
  endtask

  task automatic model_pass(output bit bnc);
    bnc = 0;
    for (int i = 0; i < N; i++) begin
      if (mh[i] == 0) begin
        if (mx[i] + HSP >= HM - BS) begin mx[i] = HM - BS; mh[i] = 1; bnc = 1; end
        else mx[i] += HSP;
      end else begin
        if (mx[i] <= HSP) begin mx[i] = 0; mh[i] = 0; bnc = 1; end
        else mx[i] -= HSP;
      end
      if (mv[i] == 0) begin
        if (my[i] + VSP >= VM - BS) begin my[i] = VM - BS; mv[i] = 1; bnc = 1; end
        else my[i] += VSP;
      end else begin
        if (my[i] <= VSP) begin my[i] = 0; mv[i] = 0; bnc = 1; end
        else my[i] -= VSP;
      end
    end
  endtask

  function automatic int model_colour(input int h, input int v, input bit d);
    if (!d) return 0;
    for (int i = 0; i < N; i++)
      if (h >= mx[i] && h < mx[i] + BS && v >= my[i] && v < my[i] + BS) return (i % 7) + 1;
    return 0;
  endfunction

  task automatic check_state(input string tag);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_x%0d", tag, i), int'(dut.x_q[i]), mx[i]);
      chk($sformatf("%s_y%0d", tag, i), int'(dut.y_q[i]), my[i]);
      chk($sformatf("%s_h%0d", tag, i), int'(dut.hdir_q[i]), mh[i]);
      chk($sformatf("%s_v%0d", tag, i), int'(dut.vdir_q[i]), mv[i]);
    end
  endtask

  task automatic probe(input int h, input int v, input bit d);
    @(negedge clk);
    hpos = 9'(h); vpos = 9'(v); display_on = d;
    @(negedge clk);
    chk($sformatf("rgb_%0d_%0d_%0d", h, v, d), int'(rgb), model_colour(h & 511, v & 511, d));
  endtask

  task automatic rand_probe();
    int i = $urandom_range(0, N - 1);
    probe(mx[i] + $urandom_range(0, BS + 3) - 2, my[i] + $urandom_range(0, BS + 3) - 2,
          $urandom_range(0, 3) != 0);
  endtask

  // One vsync pulse; 'mid' toggles pause and re-pulses vsync partway through.
  task automatic do_pass(input bit p, input bit mid);
    bit bnc;
    int nb = 0, nbo = 0;
    @(negedge clk);
    pause = p; vsync = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (busy)   nb++;
      if (bounce) nbo++;
      if (mid && c == 1) begin
        pause = ~p;
        if (!p) vsync = 1'b0;
      end
      if (mid && !p && c == 2) vsync = 1'b1;
    end
    vsync = 1'b0;
    @(negedge clk);
    bnc = 0;
    if (!p) model_pass(bnc);
    chk("busy_cycles", nb, p ? 0 : N);
    chk("bounce_pulses", nbo, (!p && bnc) ? 1 : 0);
    check_state("pass");
  endtask

  initial begin
    int nb;
    bit hit2;
    reset = 1'b1; pause = 1'b0; vsync = 1'b0; display_on = 1'b0; hpos = '0; vpos = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_bounce", int'(bounce), 0);
    chk("rst_rgb", int'(rgb), 0);
    check_state("rst");
    reset = 1'b0;

    probe(16, 16, 1); chk("rgb_ball0", int'(rgb), 1);
    probe(20, 16, 1); chk("rgb_edge", int'(rgb), 0);
    probe(16, 16, 0); chk("rgb_blank", int'(rgb), 0);

    do_pass(1'b0, 1'b0);
    chk("p1_x0", int'(dut.x_q[0]), 18);
    chk("p1_y0", int'(dut.y_q[0]), 18);
    chk("p1_x1", int'(dut.x_q[1]), 46);
    chk("p1_y1", int'(dut.y_q[1]), 42);

    for (int k = 2; k <= 119; k++) begin
      do_pass(1'b0, $urandom_range(0, 3) == 0);
      rand_probe();
      if (k == 110) begin
        chk("p110_y0", int'(dut.y_q[0]), 236);
        chk("p110_v0", int'(dut.vdir_q[0]), 1);
      end
      if (k == 118) begin
        chk("p118_x0", int'(dut.x_q[0]), 252);
        chk("p118_h0", int'(dut.hdir_q[0]), 1);
      end
      if (k == 119) chk("p119_x0", int'(dut.x_q[0]), 250);
    end

    for (int k = 0; k < 10; k++) do_pass(1'b1, $urandom_range(0, 1) == 1);

    for (int k = 0; k < 20; k++) begin
      do_pass($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      rand_probe();
      rand_probe();
    end

    // Reset on the second busy cycle aborts the pass.
    @(negedge clk);
    pause = 1'b0; vsync = 1'b1; nb = 0; hit2 = 0;
    for (int c = 0; c < 8 && !hit2; c++) begin
      @(negedge clk);
      if (busy) nb++;
      if (nb == 2) begin
        reset = 1'b1; vsync = 1'b0; hit2 = 1;
      end
    end
    chk("rmid_reached", int'(hit2), 1);
    @(negedge clk);
    chk("rmid_busy", int'(busy), 0);
    chk("rmid_bounce", int'(bounce), 0);
    chk("rmid_rgb", int'(rgb), 0);
    chk("rmid_x0", int'(dut.x_q[0]), 16);
    chk("rmid_y0", int'(dut.y_q[0]), 16);
    reset = 1'b0;
    model_reset();
    do_pass(1'b0, 1'b0);
    chk("rmid_next_x0", int'(dut.x_q[0]), 18);
    chk("rmid_next_y0", int'(dut.y_q[0]), 18);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
